softmax_ctrl: RTL
=================

SOFTMAX_CTRL -- requirements
Module: softmax_ctrl

Interface
REQ-001 Parameter SIZE, default 16: tile dimension, rows and columns per tile.
REQ-002 Parameter DP_LAT, default 2: datapath latency in cycles from dp_en to result, range 1..8.
REQ-003 Derived constant W = $clog2(SIZE): row and column index width.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port start, input, 1: pulse that begins processing one SIZE x SIZE tile.
REQ-007 Port busy, output, 1: high from the cycle after start is accepted until done.
REQ-008 Port done, output, 1: one-cycle pulse after the last output write.
REQ-009 Port rd_en / rd_row / rd_col, output, 1 / W / W: input-buffer element read request.
REQ-010 Port dp_phase, output, 2: datapath phase; 0 = idle, 1 = max, 2 = sum, 3 = norm.
REQ-011 Port dp_clr, output, 1: clears the datapath row accumulator (sum, or max when enabled).
REQ-012 Port dp_en, output, 1: datapath consumes the element read one cycle earlier.
REQ-013 Port wr_en / wr_row / wr_col, output, 1 / W / W: output-buffer write of a normalized element.
REQ-014 Port wr_ready, input, 1: output buffer can accept; low stalls the NORM pass.

Function
REQ-015 FSM states: IDLE, MAX, SUM, NORM, DRAIN, DONE.
REQ-016 IDLE to MAX on start, or IDLE to SUM when SOFTMAX_CTRL_MAXSUB_EN is undefined; start is ignored when not in IDLE.
REQ-017 Each pass walks col from 0 to SIZE-1, asserting rd_en for one element per cycle; dp_en follows rd_en by 1 cycle.
REQ-018 dp_clr is asserted for 1 cycle with the col=0 read of the first pass of each row.
REQ-019 Order within a row: MAX, then SUM, then NORM; the row then increments and the sequence returns to the first pass.
REQ-020 In NORM, wr_en with wr_row/wr_col = the read address delayed by 1+DP_LAT cycles through an address shift register.
REQ-021 While wr_ready = 0 in NORM: rd_en = 0, the column counter holds, and the delay pipeline freezes; nothing is lost or duplicated.
REQ-022 After the NORM col=SIZE-1 read of row SIZE-1, go to DRAIN until all pending writes retire, then DONE for 1 cycle (done = 1), then IDLE.
REQ-023 Counters wrap from SIZE-1 to 0; no out-of-range address is ever driven.
REQ-024 Tile latency with no stall = SIZE*SIZE*P + 1 + DP_LAT + 1 cycles from start to done, where P = 3 with the macro and P = 2 without.
REQ-025 dp_phase is 0 in IDLE, DRAIN and DONE.

Reset
REQ-026 Asserting reset (reset = 0) at any time, including mid-tile, forces IDLE immediately.
REQ-027 While in reset, all outputs are 0, counters are 0 and the delay pipeline is cleared; no write is issued after release until a new start.

Configuration
REQ-028 Macro SOFTMAX_CTRL_MAXSUB_EN defined: the MAX pass is included for max subtraction, so dp_phase=1 occurs.
REQ-029 Macro SOFTMAX_CTRL_MAXSUB_EN undefined: the MAX state is not compiled, dp_phase never equals 1, and dp_clr occurs in SUM.

Structure
REQ-030 Package softmax_pkg holds the phase enum (IDLE/MAX/SUM/NORM encodings 0..3), the FSM state typedef, and IL=4 / FL=16 fixed-point constants.
REQ-031 Sub-module softmax_addr_pipe: a parameterized, stallable delay line (DP_LAT+1 stages) carrying {valid, row, col}.

Verification
REQ-032 SIZE=4, DP_LAT=2, macro on, wr_ready=1, start pulse -> 48 reads, 16 writes in row-major order, done exactly 52 cycles after start.
REQ-033 Same setup, macro off -> 32 reads, dp_phase never 1, done at 36 cycles.
REQ-034 wr_ready low for 5 cycles at NORM row 1 col 2 -> writes resume at (1,2), done delayed by exactly 5 cycles, no duplicate addresses.
REQ-035 reset low during SUM of row 2 -> all outputs 0 same cycle; after release, no wr_en until start; a new start completes normally.
REQ-036 start re-pulsed while busy -> ignored; exactly one done and 16 writes.

Source files
------------

// File: rtl/softmax_pkg.sv
// softmax_pkg: shared types and constants for the softmax tile controller.
//   phase_e : datapath phase encoding driven on dp_phase (IDLE/MAX/SUM/NORM = 0..3)
//   state_e : controller FSM state encoding
//   IL / FL : integer / fractional bit counts of the datapath fixed-point format
// Optional feature macro: SOFTMAX_CTRL_MAXSUB_EN (adds the MAX pass / S_MAX state).
package softmax_pkg;

  localparam int IL = 4;
  localparam int FL = 16;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_MAX  = 2'd1,
    PH_SUM  = 2'd2,
    PH_NORM = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef SOFTMAX_CTRL_MAXSUB_EN
    S_MAX   = 3'd1,
`endif
    S_SUM   = 3'd2,
    S_NORM  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // Datapath phase presented for a given controller state; non-pass states are idle.
  function automatic phase_e phase_of(input state_e s);
    case (s)
`ifdef SOFTMAX_CTRL_MAXSUB_EN
      S_MAX:   phase_of = PH_MAX;
`endif
      S_SUM:   phase_of = PH_SUM;
      S_NORM:  phase_of = PH_NORM;
      default: phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/softmax_ctrl_if.sv
// softmax_ctrl_if: handshake and buffer-address bundle of the softmax controller.
//   master : host / buffer side (drives start, wr_ready)
//   slave  : controller side (drives busy, done, read/datapath/write controls)
// Parameter W: row/column index width.
interface softmax_ctrl_if #(parameter int W = 4);
  logic         start;
  logic         busy;
  logic         done;
  logic         rd_en;
  logic [W-1:0] rd_row;
  logic [W-1:0] rd_col;
  logic [1:0]   dp_phase;
  logic         dp_clr;
  logic         dp_en;
  logic         wr_en;
  logic [W-1:0] wr_row;
  logic [W-1:0] wr_col;
  logic         wr_ready;

  modport master (
    output start, wr_ready,
    input  busy, done, rd_en, rd_row, rd_col, dp_phase, dp_clr, dp_en,
           wr_en, wr_row, wr_col
  );

  modport slave (
    input  start, wr_ready,
    output busy, done, rd_en, rd_row, rd_col, dp_phase, dp_clr, dp_en,
           wr_en, wr_row, wr_col
  );
endinterface

// File: rtl/softmax_addr_pipe.sv
// softmax_addr_pipe: stallable delay line carrying {valid, row, col} of NORM reads
// so each write address lines up with the datapath result.
//   clk, reset (async active-low)
//   i_adv              : shift enable; low freezes every stage
//   i_valid/i_row/i_col: entry inserted at stage 0 on an advancing edge
//   o_valid/o_row/o_col: oldest stage (write request)
//   o_pending          : a valid entry sits in any stage other than the oldest
module softmax_addr_pipe #(
  parameter int W     = 4,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_adv,
  input  logic         i_valid,
  input  logic [W-1:0] i_row,
  input  logic [W-1:0] i_col,
  output logic         o_valid,
  output logic [W-1:0] o_row,
  output logic [W-1:0] o_col,
  output logic         o_pending
);

  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_row [DEPTH];
  logic [W-1:0]     r_col [DEPTH];

  // Stage shift; bubbles carry a zero address so idle write outputs stay at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_row[i] <= '0;
        r_col[i] <= '0;
      end
    end else if (i_adv) begin
      r_vld    <= {r_vld[DEPTH-2:0], i_valid};
      r_row[0] <= i_valid ? i_row : '0;
      r_col[0] <= i_valid ? i_col : '0;
      for (int i = 1; i < DEPTH; i++) begin
        r_row[i] <= r_row[i-1];
        r_col[i] <= r_col[i-1];
      end
    end
  end

  assign o_valid   = r_vld[DEPTH-1];
  assign o_row     = r_row[DEPTH-1];
  assign o_col     = r_col[DEPTH-1];
  assign o_pending = |r_vld[DEPTH-2:0];

endmodule

// File: rtl/softmax_ctrl.sv
// softmax_ctrl: sequences row-wise softmax over one SIZE x SIZE tile.
// Each row is walked column by column in passes (MAX, SUM, NORM); NORM reads
// produce output-buffer writes delayed by 1+DP_LAT cycles.
//   clk, reset (async active-low)
//   bus (slave): start/busy/done, rd_*, dp_phase/dp_clr/dp_en, wr_*, wr_ready
// Parameters: SIZE (tile dimension), DP_LAT (datapath latency, 1..8).
// Optional feature macro: SOFTMAX_CTRL_MAXSUB_EN -- include the MAX pass.
module softmax_ctrl
  import softmax_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int DP_LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  softmax_ctrl_if.slave  bus
);

  localparam int           W     = $clog2(SIZE);
  localparam logic [W-1:0] LAST  = W'(SIZE - 1);
  localparam int           DEPTH = DP_LAT + 1;
`ifdef SOFTMAX_CTRL_MAXSUB_EN
  localparam state_e       FIRST = S_MAX;
`else
  localparam state_e       FIRST = S_SUM;
`endif

  state_e       r_state;
  state_e       w_state_nxt;
  logic [W-1:0] r_row;
  logic [W-1:0] r_col;
  logic [W-1:0] w_row_nxt;
  logic [W-1:0] w_col_nxt;
  logic [W-1:0] w_col_inc;
  logic [W-1:0] w_row_inc;
  logic         w_col_last;
  logic         w_rd_en;
  logic         r_dp_en;
  logic         w_ins_vld;
  logic         w_pipe_vld;
  logic [W-1:0] w_pipe_row;
  logic [W-1:0] w_pipe_col;
  logic         w_pipe_pend;
  logic         w_drained;

  // Counters wrap explicitly so a non-power-of-two SIZE never yields an out-of-range index.
  assign w_col_last = (r_col == LAST);
  assign w_col_inc  = w_col_last ? '0 : r_col + W'(1);
  assign w_row_inc  = (r_row == LAST) ? '0 : r_row + W'(1);
  // The tile is finished once nothing remains behind the oldest stage and that one retires now.
  assign w_drained  = !w_pipe_pend && (!w_pipe_vld || bus.wr_ready);

  // State, row and column registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Next-state, counter and read-enable decode.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = FIRST;
          w_row_nxt   = '0;
          w_col_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
`ifdef SOFTMAX_CTRL_MAXSUB_EN
      S_MAX: begin
        w_rd_en   = 1'b1;
        w_col_nxt = w_col_inc;
        if (w_col_last) begin
          w_state_nxt = S_SUM;
        end else begin
          w_state_nxt = S_MAX;
        end
      end
`endif
      S_SUM: begin
        w_rd_en   = 1'b1;
        w_col_nxt = w_col_inc;
        if (w_col_last) begin
          w_state_nxt = S_NORM;
        end else begin
          w_state_nxt = S_SUM;
        end
      end
      S_NORM: begin
        // A full output buffer holds the column and suppresses the read.
        if (bus.wr_ready) begin
          w_rd_en   = 1'b1;
          w_col_nxt = w_col_inc;
          if (w_col_last && (r_row == LAST)) begin
            w_row_nxt   = '0;
            w_state_nxt = S_DRAIN;
          end else if (w_col_last) begin
            w_row_nxt   = w_row_inc;
            w_state_nxt = FIRST;
          end else begin
            w_state_nxt = S_NORM;
          end
        end else begin
          w_state_nxt = S_NORM;
        end
      end
      S_DRAIN: begin
        if (w_drained) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // dp_en is the read enable one cycle later: the buffer returns data then.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dp_en <= 1'b0;
    end else begin
      r_dp_en <= w_rd_en;
    end
  end

  assign w_ins_vld = w_rd_en && (r_state == S_NORM);

  softmax_addr_pipe #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_addr_pipe (
    .clk       (clk),
    .reset     (reset),
    .i_adv     (bus.wr_ready),
    .i_valid   (w_ins_vld),
    .i_row     (r_row),
    .i_col     (r_col),
    .o_valid   (w_pipe_vld),
    .o_row     (w_pipe_row),
    .o_col     (w_pipe_col),
    .o_pending (w_pipe_pend)
  );

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.rd_en    = w_rd_en;
  assign bus.rd_row   = r_row;
  assign bus.rd_col   = r_col;
  assign bus.dp_phase = phase_of(r_state);
  assign bus.dp_clr   = w_rd_en && (r_state == FIRST) && (r_col == '0);
  assign bus.dp_en    = r_dp_en;
  assign bus.wr_en    = w_pipe_vld && bus.wr_ready;
  assign bus.wr_row   = w_pipe_row;
  assign bus.wr_col   = w_pipe_col;

endmodule
